// File: rtl/led_pkg.sv
// +---------------------------------------------------------------------------
// | led_pkg : opcode constants, page and opcode-class types for the LED block
// | Rev 1.0
// +---------------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  typedef enum logic [1:0] {
    PAGE0 = 2'd0,
    PAGE1 = 2'd1,
    PAGE2 = 2'd2,
    PAGE3 = 2'd3
  } page_e;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_MEM = 2'd1,
    CLS_BR  = 2'd2,
    CLS_JMP = 2'd3
  } cls_e;

  function automatic logic [1:0] op_class(input logic [5:0] op);
    logic [1:0] cls;
    case (op)
      OP_RTYPE:     cls = CLS_ALU;
      OP_LW, OP_SW: cls = CLS_MEM;
      OP_BEQ:       cls = CLS_BR;
      OP_J:         cls = CLS_JMP;
      default:      cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// +---------------------------------------------------------------------------
// | pulse_stretcher : holds lit for CYC cycles after the last trig pulse
// | Rev 1.0
// +---------------------------------------------------------------------------
`default_nettype none

module pulse_stretcher #(
  parameter int CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic lit
);

  localparam int            CW     = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trig) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The live trigger lights the LED in the same cycle the counter is loaded.
  assign lit = (cnt_q != '0) | trig;

endmodule

`default_nettype wire

// File: rtl/led_status_ctrl.sv
// +---------------------------------------------------------------------------
// | led_status_ctrl : paged, registered debug LED controller for the CPU board
// | Optional: LED_BLINK_EN adds a pause-blink on the top LED.  Rev 1.0
// +---------------------------------------------------------------------------
`default_nettype none

module led_status_ctrl
  import led_pkg::*;
#(
  parameter int LED_W       = 8,
  parameter int STATE_W     = 4,
  parameter int FETCH_STATE = 0,
  parameter int STRETCH_CYC = 5_000_000,
  parameter int ROTATE_CYC  = 50_000_000,
  parameter int PAGE_N      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic [31:0]        mem_addr,
  input  logic [5:0]         inst,
  input  logic [STATE_W-1:0] current_state,
  input  logic               mode,
  input  logic               rst_out,
  input  logic               page_btn,
  input  logic               auto_en,
  output logic [LED_W-1:0]   led,
  output logic [1:0]         page
);

  localparam int                 RW        = (ROTATE_CYC > 1) ? $clog2(ROTATE_CYC) : 1;
  localparam logic [RW-1:0]      ROT_LAST  = RW'(ROTATE_CYC - 1);
  localparam logic [1:0]         LAST_PAGE = 2'(PAGE_N - 1);
  localparam logic [STATE_W-1:0] FETCH     = STATE_W'(FETCH_STATE);

  page_e              page_q, page_d;
  logic               btn_q;
  logic [RW-1:0]      rot_q, rot_d;
  logic [STATE_W-1:0] state_q;
  logic [LED_W-1:0]   retire_q, retire_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [LED_W-1:0]   content;
  logic               io_lit;
  logic               btn_rise;
  logic               rot_exp;
  logic               advance;
  logic               w_unused;

  assign w_unused = ^mem_addr;

  pulse_stretcher #(
    .CYC (STRETCH_CYC)
  ) u_io_stretch (
    .clk  (clk),
    .rst  (rst),
    .trig (mem_addr[31]),
    .lit  (io_lit)
  );

  assign btn_rise = page_btn & ~btn_q;
  assign rot_exp  = auto_en & ~pause & (rot_q == ROT_LAST);
  assign advance  = btn_rise | rot_exp;

  // Rotation is frozen while paused, but the button still steps pages.
  always_comb begin
    rot_d = rot_q;
    if (!auto_en || advance) begin
      rot_d = '0;
    end else if (!pause) begin
      rot_d = rot_q + RW'(1);
    end
  end

  always_comb begin
    retire_d = retire_q;
    if ((current_state == FETCH) && (state_q != FETCH) && !pause) begin
      retire_d = retire_q + LED_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q    <= 1'b0;
      rot_q    <= '0;
      state_q  <= '0;
      retire_q <= '0;
      led_q    <= '0;
    end else begin
      btn_q    <= page_btn;
      rot_q    <= rot_d;
      state_q  <= current_state;
      retire_q <= retire_d;
      led_q    <= led_d;
    end
  end

`ifdef LED_BLINK_EN
  localparam int            BLINK_CYC = (ROTATE_CYC / 4 > 0) ? ROTATE_CYC / 4 : 1;
  localparam int            BW        = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_CYC - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
`endif

  // Page FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q <= PAGE0;
    end else begin
      page_q <= page_d;
    end
  end

  // Page FSM: next state
  always_comb begin
    page_d = page_q;
    if (advance) begin
      page_d = (page_q == LAST_PAGE) ? PAGE0 : page_e'(page_q + 2'd1);
    end
  end

  // Page FSM: output (page contents)
  always_comb begin
    content = '0;
    case (page_q)
      PAGE0:   content[7:0] = {~mode, io_lit, rst_out, current_state[2:0], op_class(inst)};
      PAGE1:   content      = retire_q;
      PAGE2:   content      = mem_addr[LED_W-1:0];
      default: content      = mem_addr[31 -: LED_W];
    endcase
    led_d = content;
`ifdef LED_BLINK_EN
    led_d[LED_W-1] = content[LED_W-1] ^ (pause & blink_q);
`endif
  end

  assign led  = led_q;
  assign page = page_q;

endmodule

`default_nettype wire

// File: tb/tb_led_status_ctrl.sv
// +---------------------------------------------------------------------------
// | tb_led_status_ctrl : directed vector bench for led_status_ctrl
// | Rev 1.0
// +---------------------------------------------------------------------------
`default_nettype none

module tb_led_status_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic [31:0] mem_addr;
  logic [5:0]  inst;
  logic [3:0]  current_state;
  logic        mode;
  logic        rst_out;
  logic        page_btn;
  logic        auto_en;
  logic [7:0]  led;
  logic [1:0]  page;

  int n_vec = 0;
  int n_err = 0;

  led_status_ctrl #(
    .LED_W       (8),
    .STATE_W     (4),
    .FETCH_STATE (0),
    .STRETCH_CYC (4),
    .ROTATE_CYC  (3),
    .PAGE_N      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pause         (pause),
    .mem_addr      (mem_addr),
    .inst          (inst),
    .current_state (current_state),
    .mode          (mode),
    .rst_out       (rst_out),
    .page_btn      (page_btn),
    .auto_en       (auto_en),
    .led           (led),
    .page          (page)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  inst;
    logic [3:0]  st;
    logic        mode;
    logic        rst_out;
    logic [31:0] addr;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    page_btn = 1'b1;
    step();
    page_btn = 1'b0;
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // {inst, state, mode, rst_out, addr, expected page-0 led}
    tbl[0] = '{6'd43, 4'd3, 1'b0, 1'b1, 32'h0000_0000, 8'hAD};
    tbl[1] = '{6'd0,  4'd0, 1'b1, 1'b0, 32'h7FFF_FFFF, 8'h00};
    tbl[2] = '{6'd35, 4'd7, 1'b1, 1'b0, 32'h0000_00FF, 8'h1D};
    tbl[3] = '{6'd4,  4'd5, 1'b0, 1'b0, 32'h1234_5678, 8'h96};
    tbl[4] = '{6'd2,  4'd9, 1'b1, 1'b1, 32'h0000_0000, 8'h27};
    tbl[5] = '{6'd63, 4'd2, 1'b0, 1'b0, 32'h5555_AAAA, 8'h88};

    rst = 1'b1; pause = 1'b0; mem_addr = '0; inst = '0; current_state = '0;
    mode = 1'b1; rst_out = 1'b0; page_btn = 1'b0; auto_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led", 32'(led), 32'h00);
    chk("reset_page", 32'(page), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      inst = tbl[i].inst; current_state = tbl[i].st; mode = tbl[i].mode;
      rst_out = tbl[i].rst_out; mem_addr = tbl[i].addr;
      step();
      chk($sformatf("page0_vec%0d", i), 32'(led), 32'(tbl[i].exp));
    end

    // Single IO hit: lit for exactly four registered cycles
    inst = '0; current_state = '0; mode = 1'b1; rst_out = 1'b0;
    mem_addr = 32'h8000_0000;
    step();
    chk("io_hit_c0", 32'(led[6]), 32'h1);
    mem_addr = '0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("io_hit_c%0d", c), 32'(led[6]), (c < 4) ? 32'h1 : 32'h0);
    end

    // Re-hit two cycles in extends the window
    mem_addr = 32'h8000_0000;
    step();
    mem_addr = '0;
    step();
    mem_addr = 32'h8000_0000;
    step();
    mem_addr = '0;
    step(); step(); step();
    chk("io_rehit_c5", 32'(led[6]), 32'h1);
    step();
    chk("io_rehit_c6", 32'(led[6]), 32'h0);

    // Retire counting with and without pause
    do_reset();
    begin
      logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd0};
      for (int i = 0; i < 6; i++) begin
        current_state = seq[i];
        step();
      end
    end
    press();
    chk("retire_run_led", 32'(led), 32'h02);
    chk("retire_run_page", 32'(page), 32'h1);
    pause = 1'b1;
    begin
      logic [3:0] seq2 [4] = '{4'd1, 4'd0, 4'd1, 4'd0};
      for (int i = 0; i < 4; i++) begin
        current_state = seq2[i];
        step();
      end
    end
    pause = 1'b0;
    step();
    chk("retire_paused", 32'(led), 32'h02);

    // Address pages and button edge detection
    mem_addr = 32'h1234_5678;
    press();
    chk("page2_led", 32'(led), 32'h78);
    chk("page2_page", 32'(page), 32'h2);
    press();
    chk("page3_led", 32'(led), 32'h12);
    chk("page3_page", 32'(page), 32'h3);
    page_btn = 1'b1;
    step(); step(); step();
    chk("btn_held_single", 32'(page), 32'h0);
    page_btn = 1'b0;
    step();
    press();
    press();
    mem_addr = 32'h8000_00A5;
    step();
    chk("page2_pre_reset", 32'(led), 32'hA5);

    // Asynchronous reset mid-cycle
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'h00);
    chk("async_rst_page", 32'(page), 32'h0);
    #2;
    rst = 1'b0;
    inst = 6'd43; mem_addr = '0; mode = 1'b1; rst_out = 1'b0; current_state = '0;
    step();
    chk("post_rst_led", 32'(led), 32'h01);
    chk("post_rst_page", 32'(page), 32'h0);
    press();
    chk("post_rst_retire", 32'(led), 32'h00);

    // Auto-rotate every three cycles
    do_reset();
    auto_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("rot_k%0d", k), 32'(page), 32'((k / 3) % 4));
    end
    page_btn = 1'b1;
    step();
    chk("rot_btn_coincide", 32'(page), 32'h1);
    page_btn = 1'b0;
    step();
    chk("rot_after_k16", 32'(page), 32'h1);
    step();
    chk("rot_after_k17", 32'(page), 32'h1);
    step();
    chk("rot_after_k18", 32'(page), 32'h2);

    // Top LED while paused on page 0
    auto_en = 1'b0;
    do_reset();
    pause = 1'b1; mode = 1'b0; inst = '0; current_state = '0; rst_out = 1'b0; mem_addr = '0;
    for (int k = 1; k <= 4; k++) begin
      step();
`ifdef LED_BLINK_EN
      chk($sformatf("pause_led7_k%0d", k), 32'(led[7]), 32'(1 ^ ((k - 1) & 1)));
`else
      chk($sformatf("pause_led7_k%0d", k), 32'(led[7]), 32'h1);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Registered, multi-page debug LED controller for the multi-cycle CPU board.
- Replaces the flat combinational LED mapping with selectable pages, optional automatic rotation, an event stretcher for IO-space accesses, and a retired-instruction counter.
- Sits between the CPU datapath/control debug taps and the board LED pins.
- All outputs are registered, with one cycle of latency.

Parameters:
- LED_W, 8, LED count. Must be at least 8.
- STATE_W, 4, width of the control-FSM state tap.
- FETCH_STATE, 0, state encoding that marks instruction fetch. Used for retire counting.
- STRETCH_CYC, 5_000_000, cycles an IO-hit LED stays lit after the last hit.
- ROTATE_CYC, 50_000_000, cycles per page in auto-rotate mode.
- PAGE_N, 4, number of pages. Fixed at 4; the parameter is kept for width derivation.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pause  in  1  CPU single-step/pause indicator; freezes counters
- mem_addr  in  32  current memory address tap
- inst  in  6  opcode field of the current instruction
- current_state  in  STATE_W  control-FSM state tap
- mode  in  1  run-mode switch
- rst_out  in  1  CPU reset indicator
- page_btn  in  1  debounced level from the page button
- auto_en  in  1  1 = auto-rotate pages
- led  out  LED_W  LED drive
- page  out  2  currently displayed page

Behaviour:
- Reset (async, rst=1): led=0, page=0, retire counter=0, stretch counter=0, rotate counter=0, page_btn edge register=0.
- Opcode class, 2-bit:
  - inst==0 -> 0
  - inst==35 or 43 -> 1
  - inst==4 -> 2
  - inst==2 -> 3
  - any other opcode -> 0
- Page contents. Bits above 7 are 0 unless stated.
  - Page 0: [1:0]=class, [4:2]=current_state[2:0], [5]=rst_out, [6]=io_lit, [7]=~mode.
  - Page 1: retire counter, low LED_W bits.
  - Page 2: mem_addr[LED_W-1:0].
  - Page 3: mem_addr[31:32-LED_W].
- Latency: led(t+1) = page_contents(inputs at t, page at t).
- IO stretcher:
  - Loads STRETCH_CYC-1 whenever mem_addr[31]=1.
  - Otherwise decrements to 0 and saturates there.
  - io_lit = (counter!=0) or mem_addr[31].
  - A re-hit while lit reloads the counter.
  - Keeps running while pause=1.
- Retire counter:
  - Increments when current_state transitions from any other state into FETCH_STATE and pause=0.
  - Wraps at 2^LED_W.
- Page FSM:
  - States PAGE0→PAGE1→PAGE2→PAGE3→PAGE0.
  - Advances on a rising edge of page_btn, or when auto_en=1 and the rotate counter reaches ROTATE_CYC-1.
  - The rotate counter clears on any advance and whenever auto_en=0.
  - Button edge and rotate expiry in the same cycle: advance by exactly one page.
  - While pause=1: the rotate counter holds, but button advances still apply.
- Deasserting rst mid-operation: display restarts on PAGE0 with zeroed counters; the first led update follows on the next clk edge.

Optional Feature:
- Macro: LED_BLINK_EN.
- Defined:
  - A free-running blink divider toggles every ROTATE_CYC/4 cycles.
  - While pause=1, led[LED_W-1] is XORed with the blink phase on every page.
  - The divider resets to 0.
- Undefined: no divider exists; led[LED_W-1] is exactly the page content.

Decomposition:
- Shared package led_pkg:
  - opcode constants OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2.
  - page enum (PAGE0..PAGE3, 2-bit).
  - class codes.
- One natural sub-module: pulse_stretcher (parameter CYC, input trig, output lit). It is reusable for future IO-activity LEDs.

Test Plan:
- Reset mid-run on PAGE2 with counters non-zero -> led=0, page=0 asynchronously; after release, led[1:0] follows inst within 1 cycle.
- Page 0, inst=43, current_state=3, mode=0, rst_out=1, mem_addr=0 -> led=8'b1010_1101 one cycle later.
- mem_addr[31] pulsed high for 1 cycle, with STRETCH_CYC=4 -> led[6] high for exactly 4 cycles after the registered update, then 0. A re-pulse at cycle 2 extends it.
- FSM sequence 0,1,2,0,1,0 with pause=0, FETCH_STATE=0 -> retire count=2 on page 1. The same sequence with pause=1 -> count unchanged.
- auto_en=1, ROTATE_CYC=3 -> page 0→1→2→3→0 every 3 cycles. A page_btn edge coinciding with expiry -> single advance and the rotate counter resets.
- With LED_BLINK_EN defined, pause=1 -> led[7] toggles at the divider period. Without the macro -> led[7] is steady ~mode.
